// File: rtl/axi_slave_wr_arbiter_pkg.sv
// Shared definitions for the slave-side write-channel arbiter.
// Pure declarations: no logic and no latency.
// No flow control here; consumers carry their own handshakes.
package axi_slave_wr_arbiter_pkg;

  // Default number of masters that can target one slave port.
  localparam int DEF_NUM_MASTERS = 16;

  // Default cap on accepted writes still waiting for a B response.
  localparam int DEF_MAX_OUTSTANDING = 4;

  // Arbiter phases: waiting for a request, address offered, data open.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } wr_state_e;

  // Width of a counter that must hold 0..max_out inclusive.
  function automatic int out_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage : axi_slave_wr_arbiter_pkg

// File: rtl/axi_slave_wr_arbiter_rr_priority_select.sv
// Round-robin search: first asserted request at or after ptr_i, modulo N.
// Purely combinational, zero cycles.
// No handshake; vld_o simply reports whether any request is present.
module rr_priority_select #(
  parameter  int N     = 16,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  logic [IDX_W-1:0] cand;

  // Walk ptr, ptr+1, ... and latch the first requester found.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
  end

  // Expand the winning index; all-zero when nobody is requesting.
  always_comb begin
    onehot_o = '0;
    if (vld_o) begin
      onehot_o = N'(1) << idx_o;
    end
  end

endmodule : rr_priority_select

// File: rtl/axi_slave_wr_arbiter.sv
// Per-slave write arbiter: picks one master round-robin and owns AW then W until WLAST.
// Request-to-grant is 1 cycle; AWVALID follows the granted request combinationally.
// New grants stall while the outstanding-B count is at its limit; a live transaction always finishes.
module axi_slave_wr_arbiter
  import axi_slave_wr_arbiter_pkg::*;
#(
  parameter  int NUM_MASTERS     = DEF_NUM_MASTERS,
  parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  localparam int IDX_W           = $clog2(NUM_MASTERS),
  localparam int OUT_W           = out_w(MAX_OUTSTANDING)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_MASTERS-1:0] req_i,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic [IDX_W-1:0]       grant_idx_o,
  output logic                   aw_valid_o,
  input  logic                   aw_ready_i,
  input  logic                   w_valid_i,
  input  logic                   w_ready_i,
  input  logic                   w_last_i,
  output logic                   w_active_o,
  input  logic                   b_valid_i,
  input  logic                   b_ready_i,
  output logic [OUT_W-1:0]       outstanding_o,
  output logic                   busy_o,
  output logic                   err_o
);

  wr_state_e              state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       grant_idx_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       rr_ptr_d;
  logic                   w_active_q;
  logic                   busy_q;
  logic [OUT_W-1:0]       out_q;
  logic [OUT_W-1:0]       out_d;
  logic                   err_q;
  logic                   err_d;

  logic [NUM_MASTERS-1:0] sel_onehot;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_vld;

  logic                   aw_hs;
  logic                   w_last_hs;
  logic                   b_hs;
  logic                   can_grant;

  rr_priority_select #(
    .N (NUM_MASTERS)
  ) u_rr_sel (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .onehot_o (sel_onehot),
    .idx_o    (sel_idx),
    .vld_o    (sel_vld)
  );

  // AWVALID tracks the granted master live; the grant itself stays put if it drops.
  assign aw_valid_o = (state_q == ST_ADDR) && req_i[grant_idx_q];
  assign aw_hs      = aw_valid_o && aw_ready_i;

  // Only the final beat of the open burst ends it; beats seen elsewhere are ignored.
  assign w_last_hs  = (state_q == ST_DATA) && w_valid_i && w_ready_i && w_last_i;
  assign b_hs       = b_valid_i && b_ready_i;

  // A new grant needs a requester and room for one more unanswered write.
  assign can_grant  = sel_vld && (out_q < OUT_W'(MAX_OUTSTANDING));

  // Pointer moves one past the master that just finished, wrapping at the top.
  assign rr_ptr_d   = (grant_idx_q == IDX_W'(NUM_MASTERS - 1)) ? '0
                                                                : grant_idx_q + IDX_W'(1);

  // Arbitration FSM with registered grant, busy and W-open outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      w_active_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (can_grant) begin
            state_q     <= ST_ADDR;
            grant_q     <= sel_onehot;
            grant_idx_q <= sel_idx;
            busy_q      <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (aw_hs) begin
            state_q    <= ST_DATA;
            w_active_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_last_hs) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= rr_ptr_d;
            w_active_q <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          grant_q    <= '0;
          w_active_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding count: AW adds, B removes, both together cancel; a stray B flags an error.
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    case ({aw_hs, b_hs})
      2'b10: out_d = out_q + OUT_W'(1);
      2'b01: begin
        if (out_q == '0) begin
          err_d = 1'b1;
        end else begin
          out_d = out_q - OUT_W'(1);
        end
      end
      default: out_d = out_q;
    endcase
  end

  // Counter and sticky error state; reset drops any B still owed.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = grant_idx_q;
  assign w_active_o    = w_active_q;
  assign busy_o        = busy_q;
  assign outstanding_o = out_q;
  assign err_o         = err_q;

  // At most one master may ever own the slave port.
  a_grant_onehot0 : assert property (@(posedge aclk) disable iff (!aresetn)
    $onehot0(grant_q));

  // Grants are throttled before the counter can pass its limit.
  a_out_bound : assert property (@(posedge aclk) disable iff (!aresetn)
    out_q <= OUT_W'(MAX_OUTSTANDING));

  // W is only opened for a master that holds the grant.
  a_wactive_granted : assert property (@(posedge aclk) disable iff (!aresetn)
    w_active_q |-> (grant_q != '0));

endmodule : axi_slave_wr_arbiter

// File: tb/tb_axi_slave_wr_arbiter.sv
module tb_axi_slave_wr_arbiter;

  localparam int NM    = 16;
  localparam int MO    = 4;
  localparam int IDX_W = $clog2(NM);
  localparam int OUT_W = $clog2(MO + 1);

  logic             aclk;
  logic             aresetn;
  logic [NM-1:0]    req_i;
  logic [NM-1:0]    grant_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic             aw_valid_o;
  logic             aw_ready_i;
  logic             w_valid_i;
  logic             w_ready_i;
  logic             w_last_i;
  logic             w_active_o;
  logic             b_valid_i;
  logic             b_ready_i;
  logic [OUT_W-1:0] outstanding_o;
  logic             busy_o;
  logic             err_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  axi_slave_wr_arbiter #(
    .NUM_MASTERS     (NM),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .req_i         (req_i),
    .grant_o       (grant_o),
    .grant_idx_o   (grant_idx_o),
    .aw_valid_o    (aw_valid_o),
    .aw_ready_i    (aw_ready_i),
    .w_valid_i     (w_valid_i),
    .w_ready_i     (w_ready_i),
    .w_last_i      (w_last_i),
    .w_active_o    (w_active_o),
    .b_valid_i     (b_valid_i),
    .b_ready_i     (b_ready_i),
    .outstanding_o (outstanding_o),
    .busy_o        (busy_o),
    .err_o         (err_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven away from it.
  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic aw_hs();
    aw_ready_i = 1'b1;
    step();
    aw_ready_i = 1'b0;
    settle();
  endtask

  task automatic w_beat(input logic last);
    w_valid_i = 1'b1;
    w_ready_i = 1'b1;
    w_last_i  = last;
    step();
    w_valid_i = 1'b0;
    w_ready_i = 1'b0;
    w_last_i  = 1'b0;
    settle();
  endtask

  task automatic b_hs();
    b_valid_i = 1'b1;
    b_ready_i = 1'b1;
    step();
    b_valid_i = 1'b0;
    b_ready_i = 1'b0;
    settle();
  endtask

  initial begin
    aresetn    = 1'b0;
    req_i      = 16'hFFFF;
    aw_ready_i = 1'b0;
    w_valid_i  = 1'b0;
    w_ready_i  = 1'b0;
    w_last_i   = 1'b0;
    b_valid_i  = 1'b0;
    b_ready_i  = 1'b0;

    // Reset with every master requesting.
    repeat (3) step();
    settle();
    check("rst_grant",    32'(grant_o),       32'h0);
    check("rst_idx",      32'(grant_idx_o),   32'h0);
    check("rst_awvalid",  32'(aw_valid_o),    32'h0);
    check("rst_wactive",  32'(w_active_o),    32'h0);
    check("rst_busy",     32'(busy_o),        32'h0);
    check("rst_out",      32'(outstanding_o), 32'h0);
    check("rst_err",      32'(err_o),         32'h0);

    aresetn = 1'b1;
    step();
    settle();
    check("first_idx",    32'(grant_idx_o),   32'd0);
    check("first_grant",  32'(grant_o),       32'h0001);
    check("first_busy",   32'(busy_o),        32'h1);
    check("first_awv",    32'(aw_valid_o),    32'h1);

    // Rotation between masters 0 and 3.
    req_i = 16'h0009;
    settle();
    check("addr_awv",     32'(aw_valid_o),    32'h1);
    aw_hs();
    check("data_wact",    32'(w_active_o),    32'h1);
    check("data_awv",     32'(aw_valid_o),    32'h0);
    check("data_out",     32'(outstanding_o), 32'd1);
    w_beat(1'b1);
    check("exit_grant",   32'(grant_o),       32'h0);
    check("exit_busy",    32'(busy_o),        32'h0);
    check("exit_wact",    32'(w_active_o),    32'h0);
    check("idle_awv",     32'(aw_valid_o),    32'h0);
    step();
    settle();
    check("rot_idx3a",    32'(grant_idx_o),   32'd3);
    check("rot_grant3a",  32'(grant_o),       32'h0008);
    check("rot_awv3a",    32'(aw_valid_o),    32'h1);
    aw_hs();
    w_beat(1'b1);
    step();
    settle();
    check("rot_idx0b",    32'(grant_idx_o),   32'd0);
    aw_hs();
    w_beat(1'b1);
    step();
    settle();
    check("rot_idx3b",    32'(grant_idx_o),   32'd3);
    aw_hs();
    w_beat(1'b1);
    check("thr_out4",     32'(outstanding_o), 32'd4);

    // Throttled at the limit with the request still pending.
    repeat (3) step();
    settle();
    check("thr_busy",     32'(busy_o),        32'h0);
    check("thr_grant",    32'(grant_o),       32'h0);
    check("thr_out",      32'(outstanding_o), 32'd4);
    b_hs();
    check("thr_b_out",    32'(outstanding_o), 32'd3);
    check("thr_b_busy",   32'(busy_o),        32'h0);
    step();
    settle();
    check("thr_rel_busy", 32'(busy_o),        32'h1);
    check("thr_rel_idx",  32'(grant_idx_o),   32'd0);

    // B alone in ADDR, then AW and B on the same edge at two outstanding.
    b_hs();
    check("sim_pre_out",  32'(outstanding_o), 32'd2);
    check("sim_pre_wact", 32'(w_active_o),    32'h0);
    aw_ready_i = 1'b1;
    b_valid_i  = 1'b1;
    b_ready_i  = 1'b1;
    step();
    aw_ready_i = 1'b0;
    b_valid_i  = 1'b0;
    b_ready_i  = 1'b0;
    settle();
    check("sim_out",      32'(outstanding_o), 32'd2);
    check("sim_wact",     32'(w_active_o),    32'h1);
    check("sim_err",      32'(err_o),         32'h0);

    // Four-beat burst: only the last beat closes W.
    for (int i = 0; i < 3; i++) begin
      w_beat(1'b0);
      check("burst_hold",  32'(w_active_o),   32'h1);
    end
    w_beat(1'b1);
    check("burst_exit",   32'(w_active_o),    32'h0);
    check("burst_busy",   32'(busy_o),        32'h0);

    // W beats with nothing granted change nothing.
    req_i = 16'h0000;
    w_beat(1'b1);
    w_beat(1'b0);
    check("idlew_busy",   32'(busy_o),        32'h0);
    check("idlew_wact",   32'(w_active_o),    32'h0);
    check("idlew_out",    32'(outstanding_o), 32'd2);

    // Drain, then one B too many.
    b_hs();
    b_hs();
    check("drain_out",    32'(outstanding_o), 32'd0);
    check("drain_err",    32'(err_o),         32'h0);
    b_hs();
    check("stray_err",    32'(err_o),         32'h1);
    check("stray_out",    32'(outstanding_o), 32'd0);

    // Pointer wrap from 15 back to 0.
    req_i = 16'h4000;
    step();
    settle();
    check("wrap_idx14",   32'(grant_idx_o),   32'd14);
    aw_hs();
    w_beat(1'b1);
    req_i = 16'h8001;
    step();
    settle();
    check("wrap_idx15",   32'(grant_idx_o),   32'd15);
    check("wrap_grant15", 32'(grant_o),       32'h8000);
    aw_hs();
    w_beat(1'b1);
    step();
    settle();
    check("wrap_idx0",    32'(grant_idx_o),   32'd0);
    aw_hs();
    w_beat(1'b1);
    req_i = 16'h0000;
    b_hs();
    b_hs();
    check("wrap_out",     32'(outstanding_o), 32'd1);

    // Reset in the middle of a burst with the pointer parked at 15.
    req_i = 16'h4000;
    step();
    settle();
    aw_hs();
    w_beat(1'b1);
    req_i = 16'h8001;
    step();
    settle();
    check("mid_idx15",    32'(grant_idx_o),   32'd15);
    aw_hs();
    check("mid_wact",     32'(w_active_o),    32'h1);
    check("mid_out",      32'(outstanding_o), 32'd3);
    aresetn = 1'b0;
    settle();
    check("mrst_grant",   32'(grant_o),       32'h0);
    check("mrst_idx",     32'(grant_idx_o),   32'h0);
    check("mrst_busy",    32'(busy_o),        32'h0);
    check("mrst_wact",    32'(w_active_o),    32'h0);
    check("mrst_awv",     32'(aw_valid_o),    32'h0);
    check("mrst_out",     32'(outstanding_o), 32'd0);
    check("mrst_err",     32'(err_o),         32'h0);
    step();
    aresetn = 1'b1;
    step();
    settle();
    check("mrel_idx",     32'(grant_idx_o),   32'd0);
    check("mrel_grant",   32'(grant_o),       32'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_axi_slave_wr_arbiter
